wave_sequencer: RTL and testbench

Parametrised sample sequencer for the signal generator: a synchronous-write sample RAM plus an address engine. On each rising edge of `next` it emits the sample at the current address and advances by a programmable step within a programmable window `[start_addr, end_addr]`. It runs in loop or one-shot mode and reports busy/done status. It replaces the fixed N-sample, step-1, loop-only sample player between the rate timer (which drives `next`) and the DAC serialiser (which consumes `data`).

---
 rtl/wave_sequencer.sv | 100 ++++++++++
 tb/tb_wave_sequencer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/wave_sequencer.sv
// Sample sequencer: synchronous-write sample RAM plus an address engine that
// steps through a programmable window on each rising edge of next.
module wave_sequencer #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 64,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             next,
  input  logic             start,
  input  logic             stop,
  input  logic             mode,
  input  logic [AW-1:0]    step,
  input  logic [AW-1:0]    start_addr,
  input  logic [AW-1:0]    end_addr,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] data,
  output logic             data_valid,
  output logic [AW-1:0]    addr,
  output logic             busy,
  output logic             done
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t          state, state_nxt;
  logic [AW-1:0]   addr_nxt;
  logic [AW:0]     step_sum;
  logic            next_q;
  logic            rise;
  logic            rd_en;
  logic            done_nxt;
  logic [WIDTH-1:0] mem [DEPTH];

  assign rise = next & ~next_q & (state == RUN);
  assign busy = (state == RUN);

  // One extra bit so a carry past the top of memory reads as beyond the window.
  assign step_sum = {1'b0, addr} + {1'b0, step};

  always_comb begin
    state_nxt = state;
    addr_nxt  = addr;
    rd_en     = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (start && (start_addr <= end_addr)) begin
          addr_nxt  = start_addr;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (stop) begin
          state_nxt = IDLE;
        end else if (start) begin
          addr_nxt = start_addr;
        end else if (rise) begin
          rd_en = 1'b1;
          if (step_sum <= {1'b0, end_addr}) begin
            addr_nxt = step_sum[AW-1:0];
          end else if (!mode) begin
            addr_nxt = start_addr;
          end else begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      addr       <= '0;
      next_q     <= 1'b0;
      data       <= '0;
      data_valid <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_nxt;
      addr       <= addr_nxt;
      next_q     <= next;
      data_valid <= rd_en;
      done       <= done_nxt;
      if (rd_en) data <= mem[addr];
    end
  end

  // Contents survive reset; a write coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (rst && wr_en) mem[wr_addr] <= wr_data;
  end

endmodule

// File: tb/tb_wave_sequencer.sv
// Randomised and directed bench for wave_sequencer with a behavioural model
// feeding an expected-sample queue that a separate monitor drains.
module tb_wave_sequencer;
  localparam int WIDTH = 12;
  localparam int DEPTH = 64;
  localparam int AW    = 6;

  logic             clk = 1'b0;
  logic             rst, next, start, stop, mode, wr_en;
  logic [AW-1:0]    step, start_addr, end_addr, wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic [WIDTH-1:0] data;
  logic             data_valid, busy, done;
  logic [AW-1:0]    addr;

  wave_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .next(next), .start(start), .stop(stop),
    .mode(mode), .step(step), .start_addr(start_addr), .end_addr(end_addr),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .data(data), .data_valid(data_valid), .addr(addr), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural reference: a window walker over an array, evaluated per edge.
  logic [WIDTH:0]   exp_q[$];
  logic [WIDTH-1:0] m_mem [DEPTH];
  bit               m_run = 0;
  int               m_addr = 0;
  int               m_data = 0;
  bit               m_prev = 0;

  always @(posedge clk) begin
    int n;
    bit take;
    logic [WIDTH-1:0] old;
    bit fin;
    if (!rst) begin
      m_run = 0; m_addr = 0; m_data = 0; m_prev = 0;
    end else begin
      take = next && !m_prev && m_run;
      old  = m_mem[m_addr];
      fin  = 0;
      if (m_run && stop) begin
        m_run = 0;
      end else if (start && (m_run || start_addr <= end_addr)) begin
        m_addr = int'(start_addr);
        m_run  = 1;
      end else if (take) begin
        m_data = int'(old);
        n = m_addr + int'(step);
        if (n <= int'(end_addr)) m_addr = n;
        else if (!mode) m_addr = int'(start_addr);
        else begin m_run = 0; fin = 1; end
        exp_q.push_back({fin, old});
      end
      m_prev = next;
      if (wr_en) m_mem[wr_addr] = wr_data;
    end
  end

  // Monitor: compare on the falling edge, away from DUT updates.
  bit mon_en = 0;
  int dv_cnt = 0;
  int done_cnt = 0;
  int got_q[$];
  int want_q[$];

  always @(negedge clk) begin
    logic [WIDTH:0] e;
    if (mon_en) begin
      chk("busy", busy, m_run);
      chk("addr", addr, m_addr);
      chk("data_hold", data, m_data);
      if (done) done_cnt++;
      if (data_valid) begin
        dv_cnt++;
        got_q.push_back(int'(data));
        if (exp_q.size() == 0) begin
          chk("unexpected_valid", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("sample", data, e[WIDTH-1:0]);
          chk("done_with_valid", done, e[WIDTH]);
        end
      end else begin
        chk("done_without_valid", done, 0);
      end
      if (exp_q.size() != 0) begin
        chk("missing_valid", 0, exp_q.size());
        exp_q.delete();
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse_next();
    next = 1'b1; tick();
    next = 1'b0; tick();
  endtask

  task automatic pulse_start();
    start = 1'b1; tick();
    start = 1'b0;
  endtask

  task automatic set_win(input int s, input int e, input int st, input bit m);
    start_addr = AW'(s); end_addr = AW'(e); step = AW'(st); mode = m;
  endtask

  task automatic chk_got(input string name);
    chk({name, "_count"}, got_q.size(), want_q.size());
    for (int i = 0; i < want_q.size() && i < got_q.size(); i++)
      chk(name, got_q[i], want_q[i]);
    got_q.delete();
    want_q.delete();
  endtask

  initial begin
    rst = 1'b0; next = 1'b0; start = 1'b0; stop = 1'b0; mode = 1'b0;
    wr_en = 1'b0; step = '0; start_addr = '0; end_addr = '0;
    wr_addr = '0; wr_data = '0;

    // Reset and idle
    tick();
    mon_en = 1;
    for (int i = 0; i < 3; i++) begin next = ~next; tick(); end
    rst = 1'b1; next = 1'b0; tick();
    for (int i = 0; i < 4; i++) pulse_next();
    chk("idle_no_valid", dv_cnt, 0);

    // Load RAM
    for (int i = 0; i < DEPTH; i++) begin
      wr_en = 1'b1; wr_addr = AW'(i); wr_data = WIDTH'(100 + i); tick();
    end
    wr_en = 1'b0;

    // Loop, step 1
    set_win(2, 4, 1, 0); pulse_start(); got_q.delete();
    for (int i = 0; i < 7; i++) pulse_next();
    want_q = '{102, 103, 104, 102, 103, 104, 102};
    chk_got("loop_seq");
    chk("loop_busy", busy, 1);
    stop = 1'b1; tick(); stop = 1'b0; tick();

    // One-shot, step 3
    set_win(0, 7, 3, 1); pulse_start(); got_q.delete(); done_cnt = 0;
    for (int i = 0; i < 4; i++) pulse_next();
    want_q = '{100, 103, 106};
    chk_got("oneshot_seq");
    chk("oneshot_done", done_cnt, 1);
    chk("oneshot_busy", busy, 0);

    // Overflow past top of memory
    set_win(60, 63, 3, 0); pulse_start(); got_q.delete();
    for (int i = 0; i < 3; i++) begin
      pulse_next();
      chk("addr_not_2", addr == 2, 0);
    end
    want_q = '{160, 163, 160};
    chk_got("overflow_seq");

    // stop and start together while running
    set_win(2, 4, 1, 0); done_cnt = 0;
    stop = 1'b1; start = 1'b1; tick(); stop = 1'b0; start = 1'b0; tick();
    chk("stop_wins_busy", busy, 0);
    chk("stop_no_done", done_cnt, 0);

    // Read/write collision at the current address
    pulse_start(); got_q.delete();
    next = 1'b1; wr_en = 1'b1; wr_addr = 6'd2; wr_data = 12'd999; tick();
    next = 1'b0; wr_en = 1'b0; tick();
    for (int i = 0; i < 3; i++) pulse_next();
    want_q = '{102, 103, 104, 999};
    chk_got("collision_seq");

    // Held next
    pulse_start(); got_q.delete();
    next = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    next = 1'b0; tick();
    chk("held_next_one_valid", got_q.size(), 1);
    got_q.delete();
    stop = 1'b1; tick(); stop = 1'b0; tick();

    // Bad window
    set_win(5, 3, 1, 0); pulse_start(); tick();
    chk("bad_window_busy", busy, 0);

    // Randomised phase
    for (int c = 0; c < 600; c++) begin
      int s, e;
      rst   = ($urandom_range(0, 79) != 0);
      next  = $urandom_range(0, 1);
      start = ($urandom_range(0, 24) == 0);
      stop  = ($urandom_range(0, 39) == 0);
      wr_en = ($urandom_range(0, 3) == 0);
      wr_addr = AW'($urandom_range(0, DEPTH - 1));
      wr_data = WIDTH'($urandom_range(0, 4095));
      if ($urandom_range(0, 15) == 0) begin
        s = $urandom_range(0, DEPTH - 1);
        e = ($urandom_range(0, 7) == 0) ? $urandom_range(0, DEPTH - 1)
                                        : $urandom_range(s, DEPTH - 1);
        set_win(s, e, $urandom_range(0, 9), $urandom_range(0, 1));
      end
      tick();
    end
    rst = 1'b1; next = 1'b0; start = 1'b0; stop = 1'b0; wr_en = 1'b0;
    tick(); tick();
    chk("final_queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
